// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: owns the program counter, issues one instruction at a time
// and resolves jumps/branches. Optional retired-instruction counter enabled by RETIRE_CNT_EN.
module pc_sequencer #(
  parameter int PC_W     = 16,
  parameter int RESET_PC = 0,
  parameter int PROG_LEN = 256
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [3:0]      opcode_i,
  input  logic            ex_done_i,
  input  logic            cmp_eq_i,
  input  logic            cmp_lt_i,
  input  logic [PC_W-1:0] tgt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            issue_o,
  output logic            busy_o,
  output logic            halted_o,
  output logic            fault_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]     retired_o
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StExec  = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  localparam logic [3:0] OpJmp  = 4'b0010;
  localparam logic [3:0] OpBne  = 4'b1010;
  localparam logic [3:0] OpBeq  = 4'b1011;
  localparam logic [3:0] OpBlt  = 4'b1100;
  localparam logic [3:0] OpHalt = 4'b1110;
  localparam logic [3:0] OpTba  = 4'b1111;

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);
  // One extra bit so PROG_LEN == 2^PC_W still means "every pc is valid".
  localparam logic [PC_W:0]   ProgLen = (PC_W+1)'(PROG_LEN);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      op_q, op_d;
  logic            fault_q, fault_d;
  logic            busy_q, halted_q;

  logic [PC_W-1:0] pcInc;
  logic            fetchFault;
  logic            startOk;
  logic            isTba;
  logic            branchTaken;

  assign pcInc      = pc_q + PC_W'(1);
  assign fetchFault = ({1'b0, pc_q} >= ProgLen);
  assign startOk    = start_i && ((state_q == StIdle) || (state_q == StHalt));
  assign isTba      = (state_q == StFetch) && !fetchFault && (opcode_i == OpTba);
  assign issue_o    = (state_q == StFetch) && !fetchFault &&
                      (opcode_i != OpHalt) && (opcode_i != OpTba);

  always_comb begin
    branchTaken = 1'b0;
    case (op_q)
      OpJmp:   branchTaken = 1'b1;
      OpBeq:   branchTaken = cmp_eq_i;
      OpBne:   branchTaken = !cmp_eq_i;
      OpBlt:   branchTaken = cmp_lt_i;
      default: branchTaken = 1'b0;
    endcase
  end

  // The range check outranks the opcode: a pc past the program never issues.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          pc_d    = ResetPc;
          fault_d = 1'b0;
        end
      end
      StFetch: begin
        if (fetchFault) begin
          state_d = StHalt;
          fault_d = 1'b1;
        end else if (opcode_i == OpHalt) begin
          state_d = StHalt;
        end else if (isTba) begin
          pc_d = pcInc;
        end else begin
          op_d    = opcode_i;
          state_d = StExec;
        end
      end
      StExec: begin
        if (ex_done_i) begin
          pc_d    = branchTaken ? tgt_i : pcInc;
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (start_i) begin
          state_d = StFetch;
          pc_d    = ResetPc;
          fault_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      pc_q     <= ResetPc;
      op_q     <= 4'd0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      fault_q  <= fault_d;
      busy_q   <= (state_d == StFetch) || (state_d == StExec);
      halted_q <= (state_d == StHalt);
    end
  end

  assign pc_o     = pc_q;
  assign busy_o   = busy_q;
  assign halted_o = halted_q;
  assign fault_o  = fault_q;

`ifdef RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Completed instructions plus skipped TBA slots; saturates rather than wrapping.
  always_comb begin
    retired_d = retired_q;
    if (startOk) begin
      retired_d = 32'd0;
    end else if (((state_q == StExec) && ex_done_i) || isTba) begin
      if (retired_q != 32'hFFFF_FFFF) begin
        retired_d = retired_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;
`else
  logic unusedStartOk;
  assign unusedStartOk = startOk;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small datapath responder and an issue-pc scoreboard.
// Build with RETIRE_CNT_EN defined to also check the retired counter.
module tb_pc_sequencer;

  localparam int PcW     = 16;
  localparam int ProgLen = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic [3:0]     opcode;
  logic           exDone;
  logic           cmpEq;
  logic           cmpLt;
  logic [PcW-1:0] tgt;
  logic [PcW-1:0] pc;
  logic           issue;
  logic           busy;
  logic           halted;
  logic           fault;
`ifdef RETIRE_CNT_EN
  logic [31:0]    retired;
`endif

  logic [3:0]     rom [32];
  int             exDelay;
  int             issueCount;
  int             errors;
  int             checks;
  int             expIssueQ[$];

  pc_sequencer #(
    .PC_W(PcW),
    .RESET_PC(0),
    .PROG_LEN(ProgLen)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .start_i(start),
    .opcode_i(opcode),
    .ex_done_i(exDone),
    .cmp_eq_i(cmpEq),
    .cmp_lt_i(cmpLt),
    .tgt_i(tgt),
    .pc_o(pc),
    .issue_o(issue),
    .busy_o(busy),
    .halted_o(halted),
    .fault_o(fault)
`ifdef RETIRE_CNT_EN
    ,
    .retired_o(retired)
`endif
  );

  assign opcode = rom[pc[4:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Datapath model: answers every issue with one ex_done pulse exDelay cycles later.
  initial begin
    exDone = 1'b0;
    forever begin
      @(negedge clk);
      if (issue === 1'b1) begin
        repeat (exDelay) @(negedge clk);
        #1 exDone = 1'b1;
        @(posedge clk);
        #1 exDone = 1'b0;
      end
    end
  end

  // Every issue pulse must match the next pc queued by the stimulus.
  always @(negedge clk) begin
    if (issue === 1'b1) begin
      logic [31:0] expPc;
      issueCount++;
      expPc = (expIssueQ.size() > 0) ? 32'(expIssueQ.pop_front()) : 32'hDEAD_BEEF;
      checkOutput("issuePc", 32'(pc), expPc);
    end
  end

  task automatic pulseStart();
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] prog, input logic [15:0] tgtVal,
                               input logic eqVal, input logic ltVal, input int delay);
    for (int i = 0; i < 32; i++) begin
      rom[i] = (i < 8) ? prog[4*i +: 4] : 4'hE;
    end
    tgt        = tgtVal;
    cmpEq      = eqVal;
    cmpLt      = ltVal;
    exDelay    = delay;
    issueCount = 0;
    pulseStart();
  endtask

  task automatic pushIssues(input int first, input int last);
    for (int p = first; p <= last; p++) expIssueQ.push_back(p);
  endtask

  task automatic waitHalted(input string tag);
    int n = 0;
    while (halted !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 32'(halted), 32'd1);
  endtask

  task automatic waitIssues(input int count);
    int n = 0;
    while (issueCount < count && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("issuesSeen", 32'(issueCount >= count), 32'd1);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    issueCount = 0;
    exDelay    = 1;
    reset      = 1'b1;
    start      = 1'b0;
    cmpEq      = 1'b0;
    cmpLt      = 1'b0;
    tgt        = '0;
    for (int i = 0; i < 32; i++) rom[i] = 4'hE;

    repeat (2) @(negedge clk);
    checkOutput("resetPc", 32'(pc), 32'd0);
    checkOutput("resetIssue", 32'(issue), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetHalted", 32'(halted), 32'd0);
    checkOutput("resetFault", 32'(fault), 32'd0);
    #1 reset = 1'b0;

    // Straight-line program ending in HALT at pc=5.
    pushIssues(0, 4);
    applyStimulus(32'hEEE65131, 16'h0000, 1'b0, 1'b0, 1);
    checkOutput("startBusy", 32'(busy), 32'd1);
    waitHalted("linearHalted");
    checkOutput("linearPc", 32'(pc), 32'd5);
    checkOutput("linearFault", 32'(fault), 32'd0);
    checkOutput("linearIssues", 32'(issueCount), 32'd5);
    checkOutput("linearBusy", 32'(busy), 32'd0);
    checkOutput("linearQueue", 32'(expIssueQ.size()), 32'd0);

    // BEQ taken to 0x10, which lies past the program and faults.
    pushIssues(0, 3);
    applyStimulus(32'hEEEEB000, 16'h0010, 1'b1, 1'b0, 1);
    waitHalted("beqTakenHalted");
    checkOutput("beqTakenPc", 32'(pc), 32'h10);
    checkOutput("beqTakenFault", 32'(fault), 32'd1);

    pushIssues(0, 3);
    applyStimulus(32'hEEEEB000, 16'h0010, 1'b0, 1'b0, 1);
    checkOutput("restartFaultClear", 32'(fault), 32'd0);
    checkOutput("restartPc", 32'(pc), 32'd0);
    waitHalted("beqNotTakenHalted");
    checkOutput("beqNotTakenPc", 32'(pc), 32'd4);

    pushIssues(0, 3);
    applyStimulus(32'hEEEEA000, 16'h0010, 1'b1, 1'b0, 1);
    waitHalted("bneNotTakenHalted");
    checkOutput("bneNotTakenPc", 32'(pc), 32'd4);

    pushIssues(0, 3);
    applyStimulus(32'hEEEEA000, 16'h0010, 1'b0, 1'b0, 1);
    waitHalted("bneTakenHalted");
    checkOutput("bneTakenPc", 32'(pc), 32'h10);
    checkOutput("bneTakenFault", 32'(fault), 32'd1);

    // BLT with a slow datapath: pc must hold until ex_done.
    pushIssues(0, 3);
    applyStimulus(32'hEEEEC000, 16'h0007, 1'b0, 1'b1, 5);
    waitIssues(4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("bltHoldPc", 32'(pc), 32'd3);
      checkOutput("bltHoldBusy", 32'(busy), 32'd1);
    end
    waitHalted("bltHalted");
    checkOutput("bltPc", 32'(pc), 32'd7);
    checkOutput("bltIssues", 32'(issueCount), 32'd4);
    checkOutput("bltFault", 32'(fault), 32'd0);

    // JMP beyond PROG_LEN, then restart out of the faulted HALT.
    pushIssues(0, 2);
    applyStimulus(32'hEEEEE200, 16'h0009, 1'b0, 1'b0, 1);
    waitHalted("jmpHalted");
    checkOutput("jmpPc", 32'(pc), 32'd9);
    checkOutput("jmpFault", 32'(fault), 32'd1);
    checkOutput("jmpIssues", 32'(issueCount), 32'd3);
    pushIssues(0, 2);
    applyStimulus(32'hEEEEE200, 16'h0009, 1'b0, 1'b0, 1);
    checkOutput("jmpRestartPc", 32'(pc), 32'd0);
    checkOutput("jmpRestartFault", 32'(fault), 32'd0);
    checkOutput("jmpRestartBusy", 32'(busy), 32'd1);
    checkOutput("jmpRestartHalted", 32'(halted), 32'd0);
    waitHalted("jmpAgainHalted");

    // Reset lands in the same cycle as ex_done; the completion must be dropped.
    pushIssues(0, 0);
    applyStimulus(32'hEEEEEEE1, 16'h0000, 1'b0, 1'b0, 1);
    waitIssues(1);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("midResetPc", 32'(pc), 32'd0);
    checkOutput("midResetIssue", 32'(issue), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetHalted", 32'(halted), 32'd0);
    #1 reset = 1'b0;
    checkOutput("midResetQueue", 32'(expIssueQ.size()), 32'd0);

    // start during EXEC must be ignored.
    pushIssues(0, 1);
    applyStimulus(32'hEEEEEE10, 16'h0000, 1'b0, 1'b0, 6);
    waitIssues(2);
    pulseStart();
    checkOutput("busyStartPc", 32'(pc), 32'd1);
    checkOutput("busyStartBusy", 32'(busy), 32'd1);
    waitHalted("busyStartHalted");
    checkOutput("busyStartFinalPc", 32'(pc), 32'd2);
    checkOutput("busyStartQueue", 32'(expIssueQ.size()), 32'd0);

    // TBA is skipped without an issue.
    expIssueQ.push_back(0);
    expIssueQ.push_back(2);
    expIssueQ.push_back(3);
    applyStimulus(32'hEEEE13F1, 16'h0000, 1'b0, 1'b0, 1);
    waitHalted("tbaHalted");
    checkOutput("tbaPc", 32'(pc), 32'd4);
    checkOutput("tbaIssues", 32'(issueCount), 32'd3);
`ifdef RETIRE_CNT_EN
    checkOutput("retiredCount", retired, 32'd4);
    pushIssues(0, 0);
    expIssueQ.push_back(2);
    expIssueQ.push_back(3);
    applyStimulus(32'hEEEE13F1, 16'h0000, 1'b0, 1'b0, 1);
    checkOutput("retiredCleared", retired, 32'd0);
    waitHalted("retiredAgainHalted");
    checkOutput("retiredAgain", retired, 32'd4);
`endif
    checkOutput("finalQueue", 32'(expIssueQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL globalTimeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/execute controller for the 8-bit-instruction core. Owns the program counter that addresses instr_rom.
- Samples the decoded opcode, issues one instruction at a time to the datapath and waits for its completion.
- Resolves JMP/BNE/BEQ/BLT targets, stops on HALT, and guards against running past the end of the program.

Parameters:
- PC_W, 16, program counter width; matches the instr_rom pc port.
- RESET_PC, 0, PC value loaded on reset and on start.
- PROG_LEN, 256, number of valid ROM words. A PC >= PROG_LEN at fetch is a fault.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse; begins execution from RESET_PC when idle or halted
- opcode  input  4  instr_rom opcode for the current pc
- ex_done  input  1  datapath completed the issued instruction; only sampled in EXEC
- cmp_eq  input  1  datapath equality flag; valid while ex_done=1
- cmp_lt  input  1  datapath signed less-than flag; valid while ex_done=1
- tgt  input  PC_W  jump/branch absolute target from the register file; valid while ex_done=1
- pc  output  PC_W  program counter driving instr_rom
- issue  output  1  one-cycle pulse: datapath must execute the instruction at pc
- busy  output  1  high in FETCH or EXEC
- halted  output  1  high in HALT
- fault  output  1  sticky; set when fetch pc >= PROG_LEN

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, issue=0, busy=0, halted=0, fault=0, state=IDLE.
  - Reset in any state, including mid-EXEC, aborts immediately. Any pending ex_done is ignored.
- States: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - start=1: go to FETCH and set pc=RESET_PC.
  - Otherwise hold.
- FETCH (1 cycle; instr_rom is combinational, so opcode is valid this cycle):
  - pc >= PROG_LEN: go to HALT, fault=1, no issue. This check takes priority over opcode.
  - opcode=HALT (4'b1110): go to HALT, no issue, pc unchanged.
  - opcode=TBA (4'b1111): treated as NOP. pc=pc+1, stay in FETCH, no issue.
  - Any other opcode: issue=1 for this cycle, latch opcode, go to EXEC.
- EXEC:
  - Wait for ex_done, with no timeout. On ex_done=1, compute the next pc, then go to FETCH on the following cycle.
  - JMP (4'b0010): pc=tgt.
  - BEQ (4'b1011): pc = cmp_eq ? tgt : pc+1.
  - BNE (4'b1010): pc = !cmp_eq ? tgt : pc+1.
  - BLT (4'b1100): pc = cmp_lt ? tgt : pc+1.
  - All other opcodes: pc=pc+1.
  - Minimum instruction period: 2 cycles (FETCH, then EXEC with ex_done=1).
- HALT:
  - pc holds and halted=1.
  - start=1: pc=RESET_PC, fault cleared, go to FETCH.
- start while busy is ignored.
- ex_done outside EXEC is ignored.
- Arithmetic:
  - pc+1 is modulo 2^PC_W; 0xFFFF wraps to 0.
  - tgt is an absolute address, taken as-is. Out-of-range targets are caught by the next FETCH check.
- Outputs are registered, except issue, which is decoded from state==FETCH and the opcode conditions.

Optional Feature:
- RETIRE_CNT_EN defined:
  - Adds output retired [31:0]. It increments on every EXEC cycle with ex_done=1 and every TBA NOP in FETCH.
  - Cleared on reset and on start. Saturates at 0xFFFFFFFF.
- RETIRE_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, start pulse, opcodes LIM, INC, LIM, SFT, MVF, then HALT at pc=5, with ex_done=1 one cycle after each issue -> pc steps 0..5; five issue pulses; halted=1 at pc=5; fault=0.
- BEQ at pc=3, tgt=0x0010, cmp_eq=1 on ex_done -> next FETCH pc=0x0010. Repeat with cmp_eq=0 -> pc=4. BNE with the same stimulus -> opposite results.
- BLT with cmp_lt=1, tgt=0x0007, and ex_done delayed 5 cycles -> issue pulses once; busy=1 throughout; pc changes only after ex_done; pc=7.
- PROG_LEN=8, JMP with tgt=0x0009 -> HALT on the next FETCH; fault=1; no issue. A start pulse then -> pc=0, fault=0, FETCH.
- Reset asserted mid-EXEC with ex_done=1 in the same cycle -> next cycle state=IDLE, pc=RESET_PC, issue=0. A start pulse while busy has no effect.
- RETIRE_CNT_EN: run 3 instructions, one TBA, then HALT -> retired=4. A start pulse -> retired=0.
